ldu_iq_multi_enq: RTL and testbench

Parametrised, age-ordered, collapsing Load Unit Issue Queue that accepts up to LDU_IQ_ENQ_WIDTH load ops per cycle and issues at most one ready op per cycle, oldest first.
- Sits between the load dispatch queue and the LDU pipeline.
- Performs operand-A wakeup from the banked writeback bus, including wakeup of ops in the cycle they are enqueued.
- Adds a whole-queue flush and an occupancy count.

---
 rtl/ldu_iq_multi_enq.sv | 191 +++++++++++++++++++
 tb/tb_ldu_iq_multi_enq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldu_iq_multi_enq.sv
`timescale 1ns/1ps
// Load Unit Issue Queue: age-ordered and collapsing. It accepts up to
// LDU_IQ_ENQ_WIDTH loads per cycle and issues the oldest ready load.
// Operand A wakes up from the banked writeback bus, and this includes the
// cycle in which the load is enqueued.
module ldu_iq_multi_enq #(
  parameter int LDU_IQ_ENTRIES     = 8,
  parameter int LDU_IQ_ENQ_WIDTH   = 2,
  parameter int LOG_LDU_IQ_ENTRIES = $clog2(LDU_IQ_ENTRIES + 1),
  parameter int LOG_PR_COUNT       = 7,
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  parameter int LOG_LDU_CQ_ENTRIES = 4
) (
  input  logic                                                   CLK,
  input  logic                                                   nRST,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0]                            ldu_iq_enq_valid,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0][3:0]                       ldu_iq_enq_op,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0][11:0]                      ldu_iq_enq_imm12,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0][LOG_PR_COUNT-1:0]          ldu_iq_enq_A_PR,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0]                            ldu_iq_enq_A_ready,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0]                            ldu_iq_enq_A_is_zero,
  input  logic [LDU_IQ_ENQ_WIDTH-1:0][LOG_LDU_CQ_ENTRIES-1:0]    ldu_iq_enq_cq_index,
  output logic [LDU_IQ_ENQ_WIDTH-1:0]                            ldu_iq_enq_ready,
  input  logic [PRF_BANK_COUNT-1:0]                              WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  input  logic                                                   flush_valid,
  output logic                                                   issue_valid,
  output logic [3:0]                                             issue_op,
  output logic [11:0]                                            issue_imm12,
  output logic                                                   issue_A_forward,
  output logic                                                   issue_A_is_zero,
  output logic [LOG_PRF_BANK_COUNT-1:0]                          issue_A_bank,
  output logic [LOG_LDU_CQ_ENTRIES-1:0]                          issue_cq_index,
  output logic                                                   PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]                                PRF_req_A_PR,
  input  logic                                                   pipeline_ready,
  output logic [LOG_LDU_IQ_ENTRIES-1:0]                          ldu_iq_occupancy
);

  localparam int IDX_W   = (LDU_IQ_ENTRIES > 1) ? $clog2(LDU_IQ_ENTRIES) : 1;
  localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef struct packed {
    logic                          valid;
    logic [3:0]                    op;
    logic [11:0]                   imm12;
    logic [LOG_PR_COUNT-1:0]       a_pr;
    logic                          a_ready;
    logic                          a_is_zero;
    logic [LOG_LDU_CQ_ENTRIES-1:0] cq_index;
  } entry_t;

  entry_t                        entries_q [LDU_IQ_ENTRIES];
  entry_t                        entries_d [LDU_IQ_ENTRIES];
  logic [LOG_LDU_IQ_ENTRIES-1:0] occupancy_q, occupancy_d;

  logic [LDU_IQ_ENTRIES-1:0]     entry_fwd;
  logic [LDU_IQ_ENTRIES-1:0]     entry_rdy;
  logic                          sel_found;
  logic [IDX_W-1:0]              sel_idx;
  logic                          issue_fire;
  entry_t                        sel_entry;

  logic [LDU_IQ_ENQ_WIDTH-1:0]   enq_accept;
  logic [LDU_IQ_ENQ_WIDTH-1:0]   enq_fwd;
  int                            enq_pos [LDU_IQ_ENQ_WIDTH];
  int                            enq_slot;
  int                            survivors;
  int                            src;

  // A PR matches when its bank carries a valid writeback with the same upper bits.
  function automatic logic fwd_match(
    input logic [LOG_PR_COUNT-1:0]                  pr,
    input logic [PRF_BANK_COUNT-1:0]                wb_valid,
    input logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]   wb_upper
  );
    logic [LOG_PRF_BANK_COUNT-1:0] bank;
    bank = pr[LOG_PRF_BANK_COUNT-1:0];
    return wb_valid[bank] && (wb_upper[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
  endfunction

  // Per-entry wakeup, readiness, and selection of the oldest ready entry.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    entry_fwd = '0;
    entry_rdy = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < LDU_IQ_ENTRIES; i++) begin
      entry_fwd[i] = fwd_match(entries_q[i].a_pr, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
      entry_rdy[i] = entries_q[i].valid &
                     (entries_q[i].a_ready | entry_fwd[i] | entries_q[i].a_is_zero);
    end
    for (int i = 0; i < LDU_IQ_ENTRIES; i++) begin
      if (entry_rdy[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_fire = sel_found & pipeline_ready & ~flush_valid;

  // Issue and PRF request outputs. These are held at zero when nothing issues.
  always_comb begin
    sel_entry       = entries_q[sel_idx];
    issue_valid     = issue_fire;
    issue_op        = '0;
    issue_imm12     = '0;
    issue_A_forward = 1'b0;
    issue_A_is_zero = 1'b0;
    issue_A_bank    = '0;
    issue_cq_index  = '0;
    PRF_req_A_valid = 1'b0;
    PRF_req_A_PR    = '0;
    if (issue_fire) begin
      issue_op        = sel_entry.op;
      issue_imm12     = sel_entry.imm12;
      issue_A_forward = entry_fwd[sel_idx];
      issue_A_is_zero = sel_entry.a_is_zero;
      issue_A_bank    = sel_entry.a_pr[LOG_PRF_BANK_COUNT-1:0];
      issue_cq_index  = sel_entry.cq_index;
      PRF_req_A_valid = ~entry_fwd[sel_idx] & ~sel_entry.a_is_zero;
      PRF_req_A_PR    = sel_entry.a_pr;
    end
  end

  // Enqueue credit comes from registered occupancy only. A slot freed this cycle is offered next cycle.
  always_comb begin
    ldu_iq_enq_ready = '0;
    for (int k = 0; k < LDU_IQ_ENQ_WIDTH; k++) begin
      ldu_iq_enq_ready[k] = (LDU_IQ_ENTRIES - int'(occupancy_q)) > k;
    end
  end

  assign ldu_iq_occupancy = occupancy_q;

  // Next state: survivors collapse over the issued slot, then accepted ports append in port order.
  always_comb begin
    enq_accept = '0;
    enq_fwd    = '0;
    survivors  = int'(occupancy_q) - (issue_fire ? 1 : 0);
    enq_slot   = survivors;
    src        = 0;
    for (int k = 0; k < LDU_IQ_ENQ_WIDTH; k++) begin
      enq_accept[k] = ldu_iq_enq_valid[k] & ldu_iq_enq_ready[k] & ~flush_valid;
      enq_fwd[k]    = fwd_match(ldu_iq_enq_A_PR[k], WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
      enq_pos[k]    = enq_slot;
      if (enq_accept[k]) enq_slot = enq_slot + 1;
    end

    for (int i = 0; i < LDU_IQ_ENTRIES; i++) begin
      src = (issue_fire && (i >= int'(sel_idx))) ? i + 1 : i;
      if (src < LDU_IQ_ENTRIES) begin
        entries_d[i]         = entries_q[IDX_W'(src)];
        entries_d[i].a_ready = entries_q[IDX_W'(src)].a_ready | entry_fwd[IDX_W'(src)];
      end else begin
        entries_d[i] = '0;
      end
      for (int k = 0; k < LDU_IQ_ENQ_WIDTH; k++) begin
        if (enq_accept[k] && (enq_pos[k] == i)) begin
          entries_d[i].valid     = 1'b1;
          entries_d[i].op        = ldu_iq_enq_op[k];
          entries_d[i].imm12     = ldu_iq_enq_imm12[k];
          entries_d[i].a_pr      = ldu_iq_enq_A_PR[k];
          entries_d[i].a_ready   = ldu_iq_enq_A_ready[k] | enq_fwd[k];
          entries_d[i].a_is_zero = ldu_iq_enq_A_is_zero[k];
          entries_d[i].cq_index  = ldu_iq_enq_cq_index[k];
        end
      end
      if (flush_valid) entries_d[i].valid = 1'b0;
    end

    occupancy_d = flush_valid ? '0 : LOG_LDU_IQ_ENTRIES'(enq_slot);
  end

  // State registers for the entry array and the occupancy count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occupancy_q <= '0;
      // NOTE: the entry array is reset in full because the fields must read zero after reset, not only the valid bits.
      for (int i = 0; i < LDU_IQ_ENTRIES; i++) entries_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates, so every flop samples the pre-edge values.
      occupancy_q <= occupancy_d;
      for (int i = 0; i < LDU_IQ_ENTRIES; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_ldu_iq_multi_enq.sv
`timescale 1ns/1ps
// Scoreboard bench for ldu_iq_multi_enq. Each stimulus step queues the issue
// it expects. A negedge monitor compares every issue the DUT presents against
// the head of that queue.
module tb_ldu_iq_multi_enq;

  logic             CLK;
  logic             nRST;
  logic [1:0]       enq_valid;
  logic [1:0][3:0]  enq_op;
  logic [1:0][11:0] enq_imm;
  logic [1:0][6:0]  enq_pr;
  logic [1:0]       enq_a_ready;
  logic [1:0]       enq_a_zero;
  logic [1:0][3:0]  enq_cq;
  logic [1:0]       enq_ready;
  logic [3:0]       wb_valid;
  logic [3:0][4:0]  wb_upper;
  logic             flush_valid;
  logic             issue_valid;
  logic [3:0]       issue_op;
  logic [11:0]      issue_imm12;
  logic             issue_A_forward;
  logic             issue_A_is_zero;
  logic [1:0]       issue_A_bank;
  logic [3:0]       issue_cq_index;
  logic             PRF_req_A_valid;
  logic [6:0]       PRF_req_A_PR;
  logic             pipeline_ready;
  logic [3:0]       occupancy;

  ldu_iq_multi_enq dut (
    .CLK                     (CLK),
    .nRST                    (nRST),
    .ldu_iq_enq_valid        (enq_valid),
    .ldu_iq_enq_op           (enq_op),
    .ldu_iq_enq_imm12        (enq_imm),
    .ldu_iq_enq_A_PR         (enq_pr),
    .ldu_iq_enq_A_ready      (enq_a_ready),
    .ldu_iq_enq_A_is_zero    (enq_a_zero),
    .ldu_iq_enq_cq_index     (enq_cq),
    .ldu_iq_enq_ready        (enq_ready),
    .WB_bus_valid_by_bank    (wb_valid),
    .WB_bus_upper_PR_by_bank (wb_upper),
    .flush_valid             (flush_valid),
    .issue_valid             (issue_valid),
    .issue_op                (issue_op),
    .issue_imm12             (issue_imm12),
    .issue_A_forward         (issue_A_forward),
    .issue_A_is_zero         (issue_A_is_zero),
    .issue_A_bank            (issue_A_bank),
    .issue_cq_index          (issue_cq_index),
    .PRF_req_A_valid         (PRF_req_A_valid),
    .PRF_req_A_PR            (PRF_req_A_PR),
    .pipeline_ready          (pipeline_ready),
    .ldu_iq_occupancy        (occupancy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [11:0] imm;
    logic [3:0]  cq;
    logic        fwd;
    logic        zero;
    logic        prf_v;
    logic [6:0]  pr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input int k, input logic [3:0] op, input logic [11:0] imm,
                     input logic [6:0] pr, input logic rdy, input logic zero,
                     input logic [3:0] cq);
    enq_valid[k]   = 1'b1;
    enq_op[k]      = op;
    enq_imm[k]     = imm;
    enq_pr[k]      = pr;
    enq_a_ready[k] = rdy;
    enq_a_zero[k]  = zero;
    enq_cq[k]      = cq;
  endtask

  task automatic push(input logic [3:0] op, input logic [11:0] imm, input logic [3:0] cq,
                      input logic fwd, input logic zero, input logic prf_v,
                      input logic [6:0] pr);
    exp_t e;
    e.op = op; e.imm = imm; e.cq = cq; e.fwd = fwd; e.zero = zero; e.prf_v = prf_v; e.pr = pr;
    sb.push_back(e);
  endtask

  // Monitor: every issue is checked against the scoreboard head. Idle cycles must show all-zero outputs.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (issue_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_issue_cq", {28'b0, issue_cq_index}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("issue_cq",      {28'b0, issue_cq_index},  {28'b0, e.cq});
          check("issue_op",      {28'b0, issue_op},        {28'b0, e.op});
          check("issue_imm12",   {20'b0, issue_imm12},     {20'b0, e.imm});
          check("issue_fwd",     {31'b0, issue_A_forward}, {31'b0, e.fwd});
          check("issue_zero",    {31'b0, issue_A_is_zero}, {31'b0, e.zero});
          check("issue_bank",    {30'b0, issue_A_bank},    {30'b0, e.pr[1:0]});
          check("prf_req_valid", {31'b0, PRF_req_A_valid}, {31'b0, e.prf_v});
          check("prf_req_pr",    {25'b0, PRF_req_A_PR},    {25'b0, e.pr});
        end
      end else begin
        check("idle_outputs_zero",
              {issue_op, issue_imm12, issue_A_forward, issue_A_is_zero, issue_A_bank,
               issue_cq_index, PRF_req_A_valid, PRF_req_A_PR}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; enq_valid = '0; enq_op = '0; enq_imm = '0; enq_pr = '0;
    enq_a_ready = '0; enq_a_zero = '0; enq_cq = '0; wb_valid = '0; wb_upper = '0;
    flush_valid = 1'b0; pipeline_ready = 1'b0;
    #3;
    check("reset_occupancy",  {28'b0, occupancy},   32'd0);
    check("reset_enq_ready",  {30'b0, enq_ready},   32'd3);
    check("reset_issue_valid",{31'b0, issue_valid}, 32'd0);
    check("reset_prf_valid",  {31'b0, PRF_req_A_valid}, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    mon_en = 1'b1;

    // Single enqueue with A ready. The load issues on the following cycle with a PRF read.
    pipeline_ready = 1'b1;
    enq(0, 4'd3, 12'h010, 7'd9, 1'b1, 1'b0, 4'd0);
    push(4'd3, 12'h010, 4'd0, 1'b0, 1'b0, 1'b1, 7'd9);
    cyc(); enq_valid = '0;
    check("t1_occ_after_enq", {28'b0, occupancy}, 32'd1);
    cyc();
    check("t1_occ_after_issue", {28'b0, occupancy}, 32'd0);

    // Fill with two loads per cycle while the pipeline stalls, then drain the queue in age order.
    pipeline_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      enq(0, 4'd1, 12'(12'h100 + 2*c), 7'(16 + 2*c), 1'b1, 1'b0, 4'(2*c));
      enq(1, 4'd1, 12'(12'h101 + 2*c), 7'(17 + 2*c), 1'b1, 1'b0, 4'(2*c + 1));
      push(4'd1, 12'(12'h100 + 2*c), 4'(2*c),     1'b0, 1'b0, 1'b1, 7'(16 + 2*c));
      push(4'd1, 12'(12'h101 + 2*c), 4'(2*c + 1), 1'b0, 1'b0, 1'b1, 7'(17 + 2*c));
      cyc();
    end
    check("t2_occ_full", {28'b0, occupancy}, 32'd8);
    check("t2_enq_ready_full", {30'b0, enq_ready}, 32'd0);
    // Full queue: the issue goes ahead and both enqueue requests are refused.
    enq(0, 4'd9, 12'hFFF, 7'd1, 1'b1, 1'b0, 4'd15);
    enq(1, 4'd9, 12'hFFF, 7'd1, 1'b1, 1'b0, 4'd15);
    pipeline_ready = 1'b1;
    cyc(); enq_valid = '0;
    check("t2_occ_after_issue_full", {28'b0, occupancy}, 32'd7);
    check("t2_enq_ready_7", {30'b0, enq_ready}, 32'd1);
    repeat (7) cyc();
    check("t2_occ_drained", {28'b0, occupancy}, 32'd0);

    // Entry 0 waits on A while entry 1 issues first. A writeback then wakes entry 0 and forwards A.
    enq(0, 4'd2, 12'h0A0, 7'd5,  1'b0, 1'b0, 4'd3);
    enq(1, 4'd2, 12'h0A1, 7'd10, 1'b1, 1'b0, 4'd4);
    push(4'd2, 12'h0A1, 4'd4, 1'b0, 1'b0, 1'b1, 7'd10);
    push(4'd2, 12'h0A0, 4'd3, 1'b1, 1'b0, 1'b0, 7'd5);
    cyc(); enq_valid = '0;
    cyc();
    check("t3_occ_waiting", {28'b0, occupancy}, 32'd1);
    wb_valid[1] = 1'b1; wb_upper[1] = 5'd1;
    cyc(); wb_valid = '0; wb_upper = '0;
    check("t3_occ_done", {28'b0, occupancy}, 32'd0);

    // Wakeup in the enqueue cycle is latched. An x0 operand needs no PRF read.
    enq(0, 4'd4, 12'h0B0, 7'd6, 1'b0, 1'b0, 4'd5);
    enq(1, 4'd4, 12'h0B1, 7'd0, 1'b0, 1'b1, 4'd6);
    wb_valid[2] = 1'b1; wb_upper[2] = 5'd1;
    push(4'd4, 12'h0B0, 4'd5, 1'b0, 1'b0, 1'b1, 7'd6);
    push(4'd4, 12'h0B1, 4'd6, 1'b0, 1'b1, 1'b0, 7'd0);
    cyc(); enq_valid = '0; wb_valid = '0; wb_upper = '0;
    cyc(); cyc();
    check("t4_occ_done", {28'b0, occupancy}, 32'd0);

    // Sparse enqueue on port 1 only.
    enq(1, 4'd5, 12'h0C0, 7'd13, 1'b1, 1'b0, 4'd7);
    push(4'd5, 12'h0C0, 4'd7, 1'b0, 1'b0, 1'b1, 7'd13);
    cyc(); enq_valid = '0;
    check("t7_occ_sparse", {28'b0, occupancy}, 32'd1);
    cyc();
    check("t7_occ_done", {28'b0, occupancy}, 32'd0);

    // Occupancy 7 with both ports valid: only port 0 is accepted.
    pipeline_ready = 1'b0;
    for (int n = 0; n < 7; n++) begin
      enq_valid = '0;
      enq(n % 2, 4'd6, 12'(12'h200 + n), 7'(32 + n), 1'b1, 1'b0, 4'(8 + n));
      push(4'd6, 12'(12'h200 + n), 4'(8 + n), 1'b0, 1'b0, 1'b1, 7'(32 + n));
      if (n % 2 == 0 && n < 6) begin
        enq(1, 4'd6, 12'(12'h200 + n + 1), 7'(33 + n), 1'b1, 1'b0, 4'(9 + n));
        push(4'd6, 12'(12'h200 + n + 1), 4'(9 + n), 1'b0, 1'b0, 1'b1, 7'(33 + n));
        n++;
      end
      cyc();
    end
    enq_valid = '0;
    check("t5_occ_7", {28'b0, occupancy}, 32'd7);
    check("t5_enq_ready_01", {30'b0, enq_ready}, 32'd1);
    enq(0, 4'd7, 12'h2F0, 7'd40, 1'b1, 1'b0, 4'd15);
    enq(1, 4'd7, 12'h2F1, 7'd41, 1'b1, 1'b0, 4'd1);
    push(4'd7, 12'h2F0, 4'd15, 1'b0, 1'b0, 1'b1, 7'd40);
    cyc(); enq_valid = '0;
    check("t5_occ_8", {28'b0, occupancy}, 32'd8);
    pipeline_ready = 1'b1;
    repeat (8) cyc();
    check("t5_occ_drained", {28'b0, occupancy}, 32'd0);

    // Flush at occupancy 5: issue is suppressed, the same-cycle enqueues are dropped, and the queue empties.
    pipeline_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      enq_valid = '0;
      enq(0, 4'd8, 12'h300, 7'd50, 1'b1, 1'b0, 4'd2);
      if (c < 2) enq(1, 4'd8, 12'h301, 7'd51, 1'b1, 1'b0, 4'd3);
      cyc();
    end
    enq_valid = '0;
    check("t6_occ_5", {28'b0, occupancy}, 32'd5);
    pipeline_ready = 1'b1;
    flush_valid = 1'b1;
    enq(0, 4'd8, 12'h302, 7'd52, 1'b1, 1'b0, 4'd4);
    enq(1, 4'd8, 12'h303, 7'd53, 1'b1, 1'b0, 4'd5);
    #1;
    check("t6_flush_no_issue", {31'b0, issue_valid}, 32'd0);
    cyc(); flush_valid = 1'b0; enq_valid = '0;
    check("t6_occ_after_flush", {28'b0, occupancy}, 32'd0);
    check("t6_enq_ready_after_flush", {30'b0, enq_ready}, 32'd3);
    #1;
    check("t6_no_issue_after_flush", {31'b0, issue_valid}, 32'd0);

    repeat (2) cyc();
    check("scoreboard_empty", sb.size(), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
